vga_pixel_driver: RTL and testbench

//  Raster timing generator and VGA output stage; the consumer end of the object/priority-mux pixel chain.
//  - Issues pixelX/pixelY to every drawing object and the mux.
//  - Receives the mux's registered 8-bit RGB a fixed number of cycles later.
//  - Expands it to 24-bit colour and drives HS/VS/BLANK_N, aligned to that same pixel.
//  - Issues startOfFrame so game logic can update object positions during vertical blank.

---
 rtl/vga_pixel_driver_if.sv | 45 ++++
 rtl/vga_pixel_driver.sv | 159 +++++++++++++++
 tb/tb_vga_pixel_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_driver_if.sv
// vga_pixel_driver_if
//   Signal bundle between the raster/VGA output stage and the rest of the
//   pixel chain (drawing objects, priority mux, game logic, DAC pins).
//   Ports (through modports):
//     pixelX, pixelY   raster position issued to every drawing object
//     startOfFrame     one-clock pulse at start of vertical blank
//     RGBIn            registered 8-bit pixel {R3,G3,B2} from the mux
//     oVGA_R/G/B       expanded 24-bit colour, 0 while blanked
//     oVGA_HS/VS       syncs, active low
//     oVGA_BLANK_N     high in the visible area
//     testPatternSel   colour-bar select (only with VGA_TEST_PATTERN_EN)
//   master: the raster/VGA driver.  slave: the pixel chain / pins side.
interface vga_pixel_driver_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  RGBIn;
  logic [7:0]  oVGA_R;
  logic [7:0]  oVGA_G;
  logic [7:0]  oVGA_B;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_BLANK_N;
`ifdef VGA_TEST_PATTERN_EN
  logic        testPatternSel;
`endif

  modport master (
    output pixelX, pixelY, startOfFrame,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    input  RGBIn
`ifdef VGA_TEST_PATTERN_EN
    , input testPatternSel
`endif
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N,
    output RGBIn
`ifdef VGA_TEST_PATTERN_EN
    , output testPatternSel
`endif
  );
endinterface

// File: rtl/vga_pixel_driver.sv
// vga_pixel_driver
//   Raster timing generator and VGA output stage at the consumer end of the
//   object/priority-mux pixel chain. Issues pixelX/pixelY, receives the mux
//   pixel PIPE_LAT clocks later, expands it to 24-bit colour and drives
//   HS/VS/BLANK_N aligned to that same pixel (PIPE_LAT+1 clocks after the
//   coordinates). startOfFrame pulses once per frame at (0, V_ACTIVE).
//   Ports:
//     clk      pixel clock (25 MHz)
//     resetN   asynchronous active-low reset
//     bus      vga_pixel_driver_if.master (see interface header)
//   Build option: define VGA_TEST_PATTERN_EN to add testPatternSel, which
//   replaces RGBIn with five 128-pixel colour bars taken from the delayed
//   pixelX.
module vga_pixel_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               resetN,
  vga_pixel_driver_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LAST    = PIPE_LAT - 1;

  localparam logic [10:0] C_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] C_HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0]         r_hCnt, r_vCnt;
  logic [10:0]         w_hNext, w_vNext;
  logic                w_hWrap;
  logic                r_sof;
  logic                w_hsRaw, w_vsRaw, w_visRaw;
  logic [PIPE_LAT-1:0] r_hsDly, r_vsDly, r_visDly;
  logic [7:0]          w_pix;
  logic [7:0]          r_R, r_G, r_B;
  logic                r_hs, r_vs, r_blankN;

  always_comb begin
    w_hWrap = (r_hCnt == C_H_LAST);
    w_hNext = w_hWrap ? 11'd0 : r_hCnt + 11'd1;
    w_vNext = r_vCnt;
    if (w_hWrap) w_vNext = (r_vCnt == C_V_LAST) ? 11'd0 : r_vCnt + 11'd1;
  end

  // startOfFrame is decoded from the next counter values so the registered
  // pulse lines up with the clock where the counters read (0, V_ACTIVE).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hCnt <= 11'd0;
      r_vCnt <= 11'd0;
      r_sof  <= 1'b0;
    end else begin
      r_hCnt <= w_hNext;
      r_vCnt <= w_vNext;
      r_sof  <= (w_hNext == 11'd0) && (w_vNext == C_V_ACT);
    end
  end

  assign w_hsRaw  = !((r_hCnt >= C_HS_BEG) && (r_hCnt < C_HS_END));
  assign w_vsRaw  = !((r_vCnt >= C_VS_BEG) && (r_vCnt < C_VS_END));
  assign w_visRaw = (r_hCnt < C_H_ACT) && (r_vCnt < C_V_ACT);

  // Timing delay line matching the upstream object + mux latency.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hsDly  <= '1;
      r_vsDly  <= '1;
      r_visDly <= '0;
    end else begin
      r_hsDly[0]  <= w_hsRaw;
      r_vsDly[0]  <= w_vsRaw;
      r_visDly[0] <= w_visRaw;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_hsDly[i]  <= r_hsDly[i-1];
        r_vsDly[i]  <= r_vsDly[i-1];
        r_visDly[i] <= r_visDly[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index rides the same delay line so bars stay aligned with sync.
  logic [2:0] r_barDly [PIPE_LAT];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_LAT; i++) r_barDly[i] <= 3'd0;
    end else begin
      r_barDly[0] <= r_hCnt[9:7];
      for (int i = 1; i < PIPE_LAT; i++) r_barDly[i] <= r_barDly[i-1];
    end
  end
`endif

  always_comb begin
    w_pix = bus.RGBIn;
`ifdef VGA_TEST_PATTERN_EN
    if (bus.testPatternSel) begin
      case (r_barDly[LAST])
        3'd0:    w_pix = 8'hFF;
        3'd1:    w_pix = 8'hFC;
        3'd2:    w_pix = 8'h1F;
        3'd3:    w_pix = 8'h1C;
        3'd4:    w_pix = 8'hE3;
        default: w_pix = 8'h00;
      endcase
    end
`endif
  end

  // Bit replication gives full-scale 0x00..0xFF without arithmetic.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_R      <= 8'd0;
      r_G      <= 8'd0;
      r_B      <= 8'd0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_blankN <= 1'b0;
    end else begin
      r_hs     <= r_hsDly[LAST];
      r_vs     <= r_vsDly[LAST];
      r_blankN <= r_visDly[LAST];
      if (r_visDly[LAST]) begin
        r_R <= {w_pix[7:5], w_pix[7:5], w_pix[7:6]};
        r_G <= {w_pix[4:2], w_pix[4:2], w_pix[4:3]};
        r_B <= {4{w_pix[1:0]}};
      end else begin
        r_R <= 8'd0;
        r_G <= 8'd0;
        r_B <= 8'd0;
      end
    end
  end

  assign bus.pixelX       = r_hCnt;
  assign bus.pixelY       = r_vCnt;
  assign bus.startOfFrame = r_sof;
  assign bus.oVGA_R       = r_R;
  assign bus.oVGA_G       = r_G;
  assign bus.oVGA_B       = r_B;
  assign bus.oVGA_HS      = r_hs;
  assign bus.oVGA_VS      = r_vs;
  assign bus.oVGA_BLANK_N = r_blankN;
endmodule

// File: tb/tb_vga_pixel_driver.sv
// tb_vga_pixel_driver
//   Directed/random bench for vga_pixel_driver with a cycle-indexed raster
//   reference model. Vertical timing is shortened so whole frames stay short.
module tb_vga_pixel_driver;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 12;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int PIPE_LAT = 2;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int OUT_LAT  = PIPE_LAT + 1;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  vga_pixel_driver_if bus ();

  vga_pixel_driver #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n;
  int mode;
  bit tpOn;
  logic [7:0] lastEff;
  bit phase1;
  int sofCnt, sofFirst, sofSecond, hsLow, vsLow, white;

  function automatic logic [23:0] rgb24();
    return {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B};
  endfunction

  // Expected output at k clocks after reset release; c is the pixel value
  // presented to the output register on the previous clock.
  function automatic logic [49:0] model_out(input int k, input logic [7:0] c);
    int p, x, y, r3, g3, b2;
    logic hs, vs, vis, sof;
    logic [7:0] r8, g8, b8;
    logic [10:0] px, py;
    px  = 11'(k % H_TOT);
    py  = 11'((k / H_TOT) % V_TOT);
    sof = ((k % FRAME) == V_ACTIVE * H_TOT);
    hs = 1'b1; vs = 1'b1; vis = 1'b0; r8 = 8'd0; g8 = 8'd0; b8 = 8'd0;
    if (k >= OUT_LAT) begin
      p   = k - OUT_LAT;
      x   = p % H_TOT;
      y   = (p / H_TOT) % V_TOT;
      hs  = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
      vs  = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
      vis = (x < H_ACTIVE) && (y < V_ACTIVE);
      if (vis) begin
        r3 = int'(c) / 32;
        g3 = (int'(c) / 4) % 8;
        b2 = int'(c) % 4;
        r8 = 8'(r3 * 36 + r3 / 2);
        g8 = 8'(g3 * 36 + g3 / 2);
        b8 = 8'(b2 * 85);
      end
    end
    return {px, py, sof, r8, g8, b8, hs, vs, vis};
  endfunction

  function automatic logic [7:0] bar_colour(input int q);
    if (q < 0) return 8'h00;
    case ((q % H_TOT) / 128)
      0:       return 8'hFF;
      1:       return 8'hFC;
      2:       return 8'h1F;
      3:       return 8'h1C;
      4:       return 8'hE3;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    logic [49:0] obs, exp;
    obs = {bus.pixelX, bus.pixelY, bus.startOfFrame, bus.oVGA_R, bus.oVGA_G,
           bus.oVGA_B, bus.oVGA_HS, bus.oVGA_VS, bus.oVGA_BLANK_N};
    exp = model_out(n, lastEff);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL raster n=%0d got=%h want=%h", n, obs, exp);
    end
    if (phase1) begin
      if (n < 2 * FRAME && bus.startOfFrame === 1'b1) begin
        sofCnt++;
        if (sofCnt == 1) sofFirst = n;
        else sofSecond = n;
      end
      if (n >= OUT_LAT && n < 2 * FRAME + OUT_LAT) begin
        if (bus.oVGA_HS === 1'b0) hsLow++;
        if (bus.oVGA_VS === 1'b0) vsLow++;
      end
      if (n >= FRAME + OUT_LAT && n < 2 * FRAME + OUT_LAT && rgb24() === 24'hFFFFFF)
        white++;
    end
  endtask

  // Acts as the upstream chain: the pixel for coordinate q = n-PIPE_LAT.
  task automatic drive_now();
    int q;
    logic [7:0] rgb;
    q = n - PIPE_LAT;
    case (mode)
      0:       rgb = 8'($urandom);
      1:       rgb = (q >= 0 && (q % FRAME) == 0) ? 8'hFF : 8'h00;
      2:       rgb = 8'hFF;
      default: rgb = 8'hA9;
    endcase
    bus.RGBIn = rgb;
`ifdef VGA_TEST_PATTERN_EN
    bus.testPatternSel = tpOn;
`endif
    lastEff = tpOn ? bar_colour(q) : rgb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_now();
    drive_now();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    bus.RGBIn = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
    bus.testPatternSel = 1'b0;
`endif
    n = 0; mode = 1; tpOn = 1'b0; lastEff = 8'h00; phase1 = 1'b0;
    sofCnt = 0; sofFirst = 0; sofSecond = 0; hsLow = 0; vsLow = 0; white = 0;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_hs",     32'(bus.oVGA_HS), 32'd1);
    chk("rst_vs",     32'(bus.oVGA_VS), 32'd1);
    chk("rst_blank_n", 32'(bus.oVGA_BLANK_N), 32'd0);
    chk("rst_rgb",    32'(rgb24()), 32'd0);
    chk("rst_pixelx", 32'(bus.pixelX), 32'd0);

    @(negedge clk);
    resetN = 1'b1;
    #1;
    n = 0;
    phase1 = 1'b1;
    check_now();
    drive_now();
    while (n < 2 * FRAME + OUT_LAT) begin
      if (n == H_TOT) mode = 0;
      if (n == FRAME) mode = 2;
      step();
      if (n == PIPE_LAT) chk("align_before", 32'(bus.oVGA_BLANK_N), 32'd0);
      if (n == OUT_LAT) begin
        chk("align_white", 32'(rgb24()), 32'hFFFFFF);
        chk("align_blank_n", 32'(bus.oVGA_BLANK_N), 32'd1);
      end
      if (n == OUT_LAT + 1) chk("align_after", 32'(rgb24()), 32'd0);
    end
    phase1 = 1'b0;
    chk("sof_count",   sofCnt, 2);
    chk("sof_first",   sofFirst, V_ACTIVE * H_TOT);
    chk("sof_spacing", sofSecond - sofFirst, FRAME);
    chk("hs_low_clks", hsLow, 2 * V_TOT * H_SYNC);
    chk("vs_low_clks", vsLow, 2 * V_SYNC * H_TOT);
    chk("white_clks",  white, V_ACTIVE * H_ACTIVE);

    mode = 3;
    while (n < 2 * FRAME + 10 + OUT_LAT) step();
    chk("expand_r", 32'(bus.oVGA_R), 32'hB6);
    chk("expand_g", 32'(bus.oVGA_G), 32'h49);
    chk("expand_b", 32'(bus.oVGA_B), 32'h55);

    mode = 2;
    while (n < 2 * FRAME + 6 * H_TOT + 100) step();
    chk("pre_reset_vis", 32'(bus.oVGA_BLANK_N), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("mid_rst_rgb",     32'(rgb24()), 32'd0);
    chk("mid_rst_blank_n", 32'(bus.oVGA_BLANK_N), 32'd0);
    chk("mid_rst_hs",      32'(bus.oVGA_HS), 32'd1);
    chk("mid_rst_vs",      32'(bus.oVGA_VS), 32'd1);
    chk("mid_rst_pixelx",  32'(bus.pixelX), 32'd0);
    chk("mid_rst_pixely",  32'(bus.pixelY), 32'd0);
    chk("mid_rst_sof",     32'(bus.startOfFrame), 32'd0);

    repeat (3) @(negedge clk);
    resetN = 1'b1;
    #1;
    n = 0;
    mode = 0;
`ifdef VGA_TEST_PATTERN_EN
    tpOn = 1'b1;
`endif
    check_now();
    drive_now();
    while (bus.startOfFrame !== 1'b1 && n < 2 * FRAME) begin
      step();
`ifdef VGA_TEST_PATTERN_EN
      if (n == OUT_LAT)       chk("bar_px0",   32'(rgb24()), 32'hFFFFFF);
      if (n == OUT_LAT + 128) chk("bar_px128", 32'(rgb24()), 32'hFFFF00);
`endif
    end
    chk("sof_after_reset", n, V_ACTIVE * H_TOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
